reg_if_adapter: RTL

- Single-outstanding register-bus front end that sits directly upstream of a bank of software-accessible subregisters.
- Accepts valid/ready bus requests and decodes the word address.
- Drives per-register one-cycle write-enable and read-enable pulses with shared write data.
- Muxes register read-back into a valid/ready response carrying an error flag.

---
 rtl/reg_if_pkg.sv | 31 +++
 rtl/reg_if_decode.sv | 38 +++
 rtl/reg_if_adapter.sv | 119 +++++++++++
 3 files changed

// File: rtl/reg_if_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_if_pkg : shared types for the register-bus adapter.  Rev 1.0
// ---------------------------------------------------------------------------
package reg_if_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } reg_if_state_e;

    localparam int AddrLsb = 2;

    // Struct fields are sized for the default bus geometry.
    localparam int BusDw = 32;
    localparam int BusAw = 5;

    typedef struct packed {
        logic               write;
        logic [BusAw-1:0]   addr;
        logic [BusDw-1:0]   wdata;
        logic [BusDw/8-1:0] be;
    } reg_if_req_t;

    typedef struct packed {
        logic [BusDw-1:0] rdata;
        logic             error;
    } reg_if_rsp_t;

endpackage
`default_nettype wire

// File: rtl/reg_if_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_if_decode : word-address decode and request legality check.  Rev 1.0
// ---------------------------------------------------------------------------
module reg_if_decode
    import reg_if_pkg::*;
#(
    parameter int NumRegs = 8,
    parameter int DW      = 32,
    parameter int AW      = 5
) (
    input  logic [AW-1:0]         addr,
    input  logic                  write,
    input  logic [DW/8-1:0]       be,
    output logic [NumRegs-1:0]    sel,
    output logic [AW-AddrLsb-1:0] idx,
    output logic                  error
);

    localparam int IdxW = AW - AddrLsb;

    logic [NumRegs-1:0] hit;

    assign idx = addr[AW-1:AddrLsb];

    // An index with no matching register leaves hit all-zero.
    for (genvar i = 0; i < NumRegs; i++) begin : g_hit
        assign hit[i] = (idx == IdxW'(i));
    end

    assign error = ~(|hit)
                 | (addr[AddrLsb-1:0] != '0)
                 | (write & ~(&be));

    assign sel = error ? '0 : hit;

endmodule
`default_nettype wire

// File: rtl/reg_if_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_if_adapter : single-outstanding valid/ready front end for a register bank.  Rev 1.0
// ---------------------------------------------------------------------------
module reg_if_adapter
    import reg_if_pkg::*;
#(
    parameter int NumRegs = 8,
    parameter int DW      = BusDw,
    parameter int AW      = BusAw
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DW-1:0]         req_wdata_i,
    input  logic [DW/8-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wdata_o,
    input  logic [NumRegs*DW-1:0] reg_rdata_i
);

    localparam int IdxW = AW - AddrLsb;

    reg_if_state_e      state_q, state_d;
    reg_if_rsp_t        rsp_q, rsp_d;
    logic [NumRegs-1:0] sel, we_q, re_q;
    logic [IdxW-1:0]    idx;
    logic               dec_error;
    logic               accept;
    logic [DW-1:0]      rd_mux;
    logic [DW-1:0]      wdata_q;

    reg_if_decode #(
        .NumRegs (NumRegs),
        .DW      (DW),
        .AW      (AW)
    ) u_decode (
        .addr  (req_addr_i),
        .write (req_write_i),
        .be    (req_be_i),
        .sel   (sel),
        .idx   (idx),
        .error (dec_error)
    );

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (idx == IdxW'(i)) begin
                rd_mux = reg_rdata_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept      = 1'b1;
                    state_d     = RESP;
                    rsp_d.error = dec_error;
                    rsp_d.rdata = (req_write_i || dec_error) ? '0 : rd_mux;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pulses are launched only by acceptance, so a stalled response never re-fires them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q   <= '0;
            we_q    <= '0;
            re_q    <= '0;
            wdata_q <= '0;
        end else begin
            rsp_q <= rsp_d;
            we_q  <= (accept &&  req_write_i) ? sel : '0;
            re_q  <= (accept && !req_write_i) ? sel : '0;
            if (accept && req_write_i && !dec_error) begin
                wdata_q <= req_wdata_i;
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_error_o = rsp_q.error;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign reg_wdata_o = wdata_q;

endmodule
`default_nettype wire
